// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: holds fetch-time predictions in an in-order queue, checks each one
// against its execute-stage resolution, writes the BTB, and redirects fetch on a misprediction.
module branch_resolution_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  // fetch side
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_pred,
  input  logic [31:0]      fetch_target,
  // execute side
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_target,
  // BTB update port
  output logic             update_en,
  output logic             update_outcome,
  output logic [31:0]      update_pc,
  output logic [31:0]      update_target,
  // redirect and status
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             resolve_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [OCC_W-1:0] occ_t;

  localparam occ_t OccFull = occ_t'(DEPTH);

  // queue storage
  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] tgt_mem_q  [DEPTH];
  logic        pred_mem_q [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  occ_t occ_q, occ_d;

  logic        empty, full;
  logic        push, pop, flush, mispredict;
  logic [31:0] head_pc, head_tgt;
  logic        head_pred;

  // Queue status, handshake and misprediction detection on the head entry
  always_comb begin
    empty       = (occ_q == '0);
    full        = (occ_q == OccFull);
    pop         = resolve_valid && !empty;
    // a pop frees a slot in the same cycle, so a full queue still accepts alongside it
    fetch_ready = !full || pop;
    push        = fetch_valid && fetch_ready;
    head_pc     = pc_mem_q[head_q];
    head_tgt    = tgt_mem_q[head_q];
    head_pred   = pred_mem_q[head_q];
    mispredict  = (head_pred != resolve_taken) ||
                  (head_pred && resolve_taken && (head_tgt != resolve_target));
    flush       = pop && mispredict;
  end

  // Next pointer/occupancy state; a flush discards everything including a same-cycle push
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      head_d = head_q + ptr_t'(1);
      tail_d = head_q + ptr_t'(1);
      occ_d  = '0;
    end else begin
      if (push) tail_d = tail_q + ptr_t'(1);
      if (pop)  head_d = head_q + ptr_t'(1);
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + occ_t'(1);
        2'b01:   occ_d = occ_q - occ_t'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Queue entry write at the tail
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        tgt_mem_q[i]  <= '0;
        pred_mem_q[i] <= 1'b0;
      end
    end else if (push && !flush) begin
      pc_mem_q[tail_q]   <= fetch_pc;
      tgt_mem_q[tail_q]  <= fetch_target;
      pred_mem_q[tail_q] <= fetch_pred;
    end
  end

  // Registered BTB update and redirect; strobes pulse for one cycle per pop
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      update_en      <= 1'b0;
      update_outcome <= 1'b0;
      update_pc      <= '0;
      update_target  <= '0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      update_en <= pop;
      redirect  <= flush;
      if (pop) begin
        update_outcome <= resolve_taken;
        update_pc      <= head_pc;
        update_target  <= resolve_taken ? resolve_target : head_tgt;
        redirect_pc    <= resolve_taken ? resolve_target : head_pc + 32'd4;
      end
    end
  end

  // Sticky error flag and saturating statistics counters
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      resolve_err <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve_valid && empty) resolve_err <= 1'b1;
      if (pop && (branch_cnt != '1))    branch_cnt  <= branch_cnt + CNT_W'(1);
      if (flush && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit: a vector table for single-branch flows plus
// hand-written sequences for full-queue, flush, empty-resolve, wrap, async clear and saturation.
module tb_branch_resolution_unit;

  logic        clk = 1'b0;
  logic        clear;
  logic        fetch_valid, fetch_ready, fetch_pred;
  logic [31:0] fetch_pc, fetch_target;
  logic        resolve_valid, resolve_taken;
  logic [31:0] resolve_target;
  logic        update_en, update_outcome, redirect, resolve_err;
  logic [31:0] update_pc, update_target, redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;

  // small-counter instance for saturation
  logic        s_clear, s_fv, s_fready, s_rv, s_en, s_out, s_red, s_err;
  logic [31:0] s_upc, s_utgt, s_rpc;
  logic [1:0]  s_bc, s_mc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_resolution_unit #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .clear(clear),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_pred(fetch_pred), .fetch_target(fetch_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .update_en(update_en), .update_outcome(update_outcome), .update_pc(update_pc),
    .update_target(update_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .resolve_err(resolve_err), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolution_unit #(.DEPTH(2), .CNT_W(2)) dut_sat (
    .clk(clk), .clear(s_clear),
    .fetch_valid(s_fv), .fetch_ready(s_fready), .fetch_pc(32'h40),
    .fetch_pred(1'b0), .fetch_target(32'h0),
    .resolve_valid(s_rv), .resolve_taken(1'b1), .resolve_target(32'h80),
    .update_en(s_en), .update_outcome(s_out), .update_pc(s_upc),
    .update_target(s_utgt), .redirect(s_red), .redirect_pc(s_rpc),
    .resolve_err(s_err), .branch_cnt(s_bc), .mispred_cnt(s_mc)
  );

  typedef struct packed {
    logic        fv;
    logic [31:0] fpc;
    logic        fpred;
    logic [31:0] ftgt;
    logic        rv;
    logic        rtaken;
    logic [31:0] rtgt;
    logic        en;
    logic        out;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        red;
    logic [31:0] rpc;
    logic [15:0] bc;
    logic [15:0] mc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  task automatic drv(input logic fv, input logic [31:0] fpc, input logic fpred,
                     input logic [31:0] ftgt, input logic rv, input logic rt,
                     input logic [31:0] rtgt);
    fetch_valid    = fv;
    fetch_pc       = fpc;
    fetch_pred     = fpred;
    fetch_target   = ftgt;
    resolve_valid  = rv;
    resolve_taken  = rt;
    resolve_target = rtgt;
  endtask

  // one clock, then sample on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //           fv fpc          pr ftgt         rv rt rtgt        en out upc          utgt         red rpc          bc mc
    vecs[0] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   16'd0, 16'd0};
    vecs[1] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h200, 16'd1, 16'd0};
    vecs[2] = '{1'b1, 32'h40,  1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   16'd1, 16'd0};
    vecs[3] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h40,  32'h80,  1'b1, 32'h44,  16'd2, 16'd1};
    vecs[4] = '{1'b1, 32'h500, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   16'd2, 16'd1};
    vecs[5] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h304, 1'b1, 1'b1, 32'h500, 32'h304, 1'b1, 32'h304, 16'd3, 16'd2};
    vecs[6] = '{1'b1, 32'h600, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   16'd3, 16'd2};
    // correct not-taken pop with a same-cycle push
    vecs[7] = '{1'b1, 32'h700, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h600, 32'h0,   1'b0, 32'h604, 16'd4, 16'd2};
    vecs[8] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h900, 1'b1, 1'b1, 32'h700, 32'h900, 1'b1, 32'h900, 16'd5, 16'd3};
    vecs[9] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   16'd5, 16'd3};

    clear   = 1'b1;
    s_clear = 1'b1;
    s_fv    = 1'b0;
    s_rv    = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst.fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst.update_en", 32'(update_en), 32'd0);
    chk("rst.redirect", 32'(redirect), 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'd0);
    chk("rst.resolve_err", 32'(resolve_err), 32'd0);
    chk("rst.branch_cnt", 32'(branch_cnt), 32'd0);
    chk("rst.mispred_cnt", 32'(mispred_cnt), 32'd0);
    @(negedge clk);
    clear   = 1'b0;
    s_clear = 1'b0;

    // table-driven single-branch flows
    for (int i = 0; i < 10; i++) begin
      drv(vecs[i].fv, vecs[i].fpc, vecs[i].fpred, vecs[i].ftgt,
          vecs[i].rv, vecs[i].rtaken, vecs[i].rtgt);
      step();
      chk($sformatf("v%0d.update_en", i), 32'(update_en), 32'(vecs[i].en));
      chk($sformatf("v%0d.redirect", i), 32'(redirect), 32'(vecs[i].red));
      if (vecs[i].en) begin
        chk($sformatf("v%0d.update_outcome", i), 32'(update_outcome), 32'(vecs[i].out));
        chk($sformatf("v%0d.update_pc", i), update_pc, vecs[i].upc);
        chk($sformatf("v%0d.update_target", i), update_target, vecs[i].utgt);
        chk($sformatf("v%0d.redirect_pc", i), redirect_pc, vecs[i].rpc);
      end
      chk($sformatf("v%0d.branch_cnt", i), 32'(branch_cnt), 32'(vecs[i].bc));
      chk($sformatf("v%0d.mispred_cnt", i), 32'(mispred_cnt), 32'(vecs[i].mc));
    end

    // fill the queue
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 32'h1000 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
    end
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 chk("full.fetch_ready", 32'(fetch_ready), 32'd0);
    // push while full is ignored
    drv(1'b1, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("full_ign.update_en", 32'(update_en), 32'd0);
    // push + correct pop while full
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1 chk("full_pop.fetch_ready", 32'(fetch_ready), 32'd1);
    drv(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    chk("full_pop.update_en", 32'(update_en), 32'd1);
    chk("full_pop.update_pc", update_pc, 32'h1000);
    chk("full_pop.redirect", 32'(redirect), 32'd0);
    chk("full_pop.branch_cnt", 32'(branch_cnt), 32'd6);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 chk("still_full.fetch_ready", 32'(fetch_ready), 32'd0);
    // mispredict head with 3 younger entries, plus a same-cycle push that must be dropped
    drv(1'b1, 32'h6000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h5000);
    step();
    chk("flush.update_pc", update_pc, 32'h1004);
    chk("flush.redirect", 32'(redirect), 32'd1);
    chk("flush.redirect_pc", redirect_pc, 32'h5000);
    chk("flush.mispred_cnt", 32'(mispred_cnt), 32'd4);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 chk("flush.fetch_ready", 32'(fetch_ready), 32'd1);
    // queue must now be empty: resolve raises resolve_err and pops nothing
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h7000);
    step();
    chk("empty.resolve_err", 32'(resolve_err), 32'd1);
    chk("empty.update_en", 32'(update_en), 32'd0);
    chk("empty.redirect", 32'(redirect), 32'd0);
    chk("empty.branch_cnt", 32'(branch_cnt), 32'd7);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("sticky.resolve_err", 32'(resolve_err), 32'd1);

    // pc+4 wraps at the top of the address space
    drv(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    step();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    chk("wrap.update_en", 32'(update_en), 32'd1);
    chk("wrap.redirect", 32'(redirect), 32'd1);
    chk("wrap.redirect_pc", redirect_pc, 32'h0);
    chk("wrap.update_target", update_target, 32'h10);
    chk("wrap.branch_cnt", 32'(branch_cnt), 32'd8);
    chk("wrap.mispred_cnt", 32'(mispred_cnt), 32'd5);

    // asynchronous clear between clock edges
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 clear = 1'b1;
    #1;
    chk("aclr.update_en", 32'(update_en), 32'd0);
    chk("aclr.redirect", 32'(redirect), 32'd0);
    chk("aclr.redirect_pc", redirect_pc, 32'd0);
    chk("aclr.update_pc", update_pc, 32'd0);
    chk("aclr.resolve_err", 32'(resolve_err), 32'd0);
    chk("aclr.branch_cnt", 32'(branch_cnt), 32'd0);
    chk("aclr.mispred_cnt", 32'(mispred_cnt), 32'd0);
    chk("aclr.fetch_ready", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    clear = 1'b0;

    // saturation on the 2-bit-counter instance: every pop mispredicts
    for (int n = 1; n <= 5; n++) begin
      s_fv = 1'b1;
      s_rv = 1'b0;
      step();
      s_fv = 1'b0;
      s_rv = 1'b1;
      step();
      s_rv = 1'b0;
      chk($sformatf("sat%0d.branch_cnt", n), 32'(s_bc), (n > 3) ? 32'd3 : 32'(n));
      chk($sformatf("sat%0d.mispred_cnt", n), 32'(s_mc), (n > 3) ? 32'd3 : 32'(n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
